// File: rtl/transpose_pkg.sv
// Shared types and sizing helpers for the ping-pong transpose buffer.
package transpose_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  localparam int DEF_DIM = 8;
  localparam int IDX_W   = clog2(DEF_DIM);
  localparam int CNT_W   = 2 * IDX_W;

endpackage

// File: rtl/transpose_buffer_pp_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module tb_dpram
  import transpose_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds its value while re is low, so it doubles as a pipeline stage
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/transpose_buffer_pp.sv
// Ping-pong DIM x DIM block transpose buffer: row-major in, column-major out.
// Optional macro TB_BYPASS_EN adds a per-block row-major pass-through input.
module transpose_buffer_pp
  import transpose_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DIM    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
`ifdef TB_BYPASS_EN
  output logic              out_last,
  input  logic              bypass
`else
  output logic              out_last
`endif
);

  localparam int IW = clog2(DIM);
  localparam int CW = 2 * IW;
  localparam int AW = CW + 1;

  bank_state_t       bstate [2];
  logic              wbank, rbank;
  logic [CW-1:0]     wcnt, rcnt;
  logic              wr_en, rd_ok, rd_en, rd_byp;
  logic [AW-1:0]     waddr, raddr;

  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1, first_p1, last_p1;

  logic [1:0]        occ;
  logic [DATA_W-1:0] data_p2  [2];
  logic              first_p2 [2];
  logic              last_p2  [2];
  logic              move, pop, push_idx;

`ifdef TB_BYPASS_EN
  logic byp [2];

  always_ff @(posedge clk) begin
    if (rst) byp <= '{default: 1'b0};
    else if (wr_en && (wcnt == '0)) byp[wbank] <= bypass;
  end

  assign rd_byp = byp[rbank];
`else
  assign rd_byp = 1'b0;
`endif

  assign in_ready = (bstate[wbank] == EMPTY) || (bstate[wbank] == FILLING);
  assign wr_en    = in_valid && in_ready;
  assign waddr    = {wbank, wcnt};

  // Read issue looks only at registered occupancy, never at out_ready
  assign rd_ok = (bstate[rbank] == FULL) || (bstate[rbank] == DRAINING);
  assign move  = vld_p1 && (occ != 2'd2);
  assign rd_en = rd_ok && (!vld_p1 || move);
  assign raddr = rd_byp ? {rbank, rcnt} : {rbank, rcnt[IW-1:0], rcnt[CW-1:IW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate <= '{default: EMPTY};
      wbank  <= 1'b0;
      rbank  <= 1'b0;
      wcnt   <= '0;
      rcnt   <= '0;
    end else begin
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == '1) begin
          bstate[wbank] <= FULL;
          wbank         <= ~wbank;
        end else begin
          bstate[wbank] <= FILLING;
        end
      end
      if (rd_en) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == '1) begin
          bstate[rbank] <= EMPTY;
          rbank         <= ~rbank;
        end else begin
          bstate[rbank] <= DRAINING;
        end
      end
    end
  end

  tb_dpram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (rdata_p1)
  );

  // Stage p1: RAM output register with block tags from the read count
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (rd_en) vld_p1 <= 1'b1;
    else if (move) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      first_p1 <= (rcnt == '0);
      last_p1  <= (rcnt == '1);
    end
  end

  // Stage p2: two-entry skid buffer, entry 0 is the output head
  assign pop      = out_valid && out_ready;
  assign push_idx = (occ == 2'd1) && !pop;

  always_ff @(posedge clk) begin
    if (rst) occ <= '0;
    else begin
      case ({move, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      data_p2[0]  <= data_p2[1];
      first_p2[0] <= first_p2[1];
      last_p2[0]  <= last_p2[1];
    end
    if (move) begin
      data_p2[push_idx]  <= rdata_p1;
      first_p2[push_idx] <= first_p1;
      last_p2[push_idx]  <= last_p1;
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? data_p2[0] : '0;
  assign out_first = out_valid && first_p2[0];
  assign out_last  = out_valid && last_p2[0];

endmodule

// File: tb/tb_transpose_buffer_pp.sv
// Scoreboard bench for transpose_buffer_pp: a block-level model predicts output order.
module tb_transpose_buffer_pp;
  import transpose_pkg::*;

  localparam int DATA_W = 12;
  localparam int DIM    = 1 << IDX_W;
  localparam int NS     = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_first;
  logic              out_last;
  logic              byp_now;
`ifdef TB_BYPASS_EN
  logic              bypass;
  assign byp_now = bypass;
`else
  assign byp_now = 1'b0;
`endif

  transpose_buffer_pp #(.DATA_W(DATA_W), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
`ifdef TB_BYPASS_EN
    .out_last  (out_last),
    .bypass    (bypass)
`else
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              f;
    logic              l;
  } exp_t;

  exp_t              sbq [$];
  logic [DATA_W-1:0] blk [$];
  logic              blk_byp;
  exp_t              e_new, e_pop;
  int                rr, cc;
  int                n_chk = 0, n_fail = 0, n_acc = 0, n_out = 0;
  logic              hold_p = 1'b0;
  logic [DATA_W-1:0] hold_d;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model + monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      blk.delete();
      sbq.delete();
      hold_p = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        n_acc++;
        if (blk.size() == 0) blk_byp = byp_now;
        blk.push_back(in_data);
        if (blk.size() == NS) begin
          for (int j = 0; j < NS; j++) begin
            rr = j % DIM;
            cc = j / DIM;
            e_new.d = blk_byp ? blk[j] : blk[rr*DIM + cc];
            e_new.f = (j == 0);
            e_new.l = (j == NS-1);
            sbq.push_back(e_new);
          end
          blk.delete();
        end
      end
      if (out_valid) begin
        if (hold_p) chk("stall_hold_data", out_data, hold_d);
        if (out_ready) begin
          if (sbq.size() == 0) chk("unexpected_out", sbq.size(), 1);
          else begin
            e_pop = sbq.pop_front();
            chk("out_data", out_data, e_pop.d);
            chk("out_first", out_first, e_pop.f);
            chk("out_last", out_last, e_pop.l);
          end
          n_out++;
          hold_p = 1'b0;
        end else begin
          hold_p = 1'b1;
          hold_d = out_data;
        end
      end else begin
        if (hold_p) chk("valid_dropped", out_valid, 1);
        hold_p = 1'b0;
        chk("idle_tags", {out_first, out_last}, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sbq.size() != 0 || out_valid) && k < 5000) begin
      step();
      k++;
    end
    chk("drain_done", sbq.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, out0, run, drop;
    logic run_done;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef TB_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);

    // 1: counting block, latency of two edges after the last accept
    out_ready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      step();
    end
    in_valid = 1'b0;
    chk("t1_lat_edge0", out_valid, 0);
    step();
    chk("t1_lat_edge1", out_valid, 0);
    step();
    chk("t1_lat_edge2", out_valid, 1);
    wait_drain();

    // 2: three back-to-back blocks at full rate
    acc0 = n_acc; run = 0; run_done = 1'b0; drop = 0;
    for (int k = 0; k < 300; k++) begin
      in_valid = ((n_acc - acc0) < 3*NS);
      in_data  = DATA_W'($urandom);
      if (in_valid && !in_ready) drop++;
      step();
      if (out_valid && !run_done) run++;
      else if (run > 0) run_done = 1'b1;
    end
    in_valid = 1'b0;
    chk("t2_ready_drop", drop, 0);
    chk("t2_valid_run", run, 3*NS);
    wait_drain();

    // 3: downstream blocked, both banks fill
    out_ready = 1'b0;
    acc0 = n_acc;
    for (int k = 0; k < 200; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("t3_accepted", n_acc - acc0, 2*NS);
    chk("t3_in_ready", in_ready, 0);
    out0 = n_out;
    wait_drain();
    chk("t3_drained", n_out - out0, 2*NS);

    // 4: random handshakes over 20 blocks
    acc0 = n_acc; out0 = n_out;
    for (int k = 0; k < 20000 && (n_acc - acc0) < 20*NS; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DATA_W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    chk("t4_accepted", n_acc - acc0, 20*NS);
    wait_drain();
    chk("t4_out_count", n_out - out0, 20*NS);

    // 5: reset mid-block with a full block waiting
    out_ready = 1'b0;
    for (int i = 0; i < NS + 30; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      step();
    end
    chk("t5_pre_valid", out_valid, 1);
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_data", out_data, 0);
    out0 = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      step();
    end
    wait_drain();
    chk("t5_fresh_count", n_out - out0, NS);

`ifdef TB_BYPASS_EN
    // 6: bypass block A, transposed block B
    out0 = n_out;
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NS; i++) begin
        in_valid = 1'b1;
        in_data  = DATA_W'(i);
        bypass   = (b == 0) ? ((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)))
                            : ((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
        step();
      end
    end
    in_valid = 1'b0;
    bypass   = 1'b0;
    wait_drain();
    chk("t6_out_count", n_out - out0, 2*NS);
`endif

    chk("final_queue_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
